// File: rtl/bus_generator_and_arbiter_if.sv
// Bundled FIFO-side signals of the bus generator/arbiter (dut_compl_if).
// The master modport is the arbiter side; the slave modport is the FIFO side.
//
// Handshake: pndng[b][d] is the source's "valid" (FIFO d non-empty, D_pop[b][d]
// already shows the head word). pop[b][d] is a one-cycle dequeue acknowledge;
// the head word is taken on the clock edge that ends the pop cycle.
// push[b][d] is a one-cycle enqueue strobe with D_push[b] as data; the
// destination FIFOs are assumed always able to accept it (no back-pressure).
interface dut_compl_if #(
  parameter int bits    = 1,
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);
  logic [bits-1:0][drvrs-1:0]              pndng;
  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [bits-1:0][drvrs-1:0]              pop;
  logic [bits-1:0][drvrs-1:0]              push;
  logic [bits-1:0][pckg_sz-1:0]            D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_generator_and_arbiter.sv
// Shared-bus generator with a round-robin arbiter per bus.
// Each of the `bits` buses runs an independent IDLE -> POP -> PUSH loop:
// grant one pending source, pop its head packet, push it to the
// destination(s) selected by the 8-bit ID in the packet's top byte.
// Optional feature macro: BROADCAST_EN enables the broadcast ID decode
// (ID == broadcast delivers to every driver except the source).
module bus_generator_and_arbiter #(
  parameter int         bits      = 1,
  parameter int         drvrs     = 4,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  dut_compl_if.master           bus,
  output logic [bits-1:0][1:0]  dbg_state
);

  localparam int sw = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

`ifndef BROADCAST_EN
  // Broadcast ID is only decoded with the feature enabled.
  logic unused_broadcast;
  assign unused_broadcast = ^broadcast;
`endif

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_t               state;
    logic [sw-1:0]        rr_ptr;
    logic [sw-1:0]        src;
    logic [sw-1:0]        sel;
    logic                 found;
    logic [drvrs-1:0]     pop_r;
    logic [drvrs-1:0]     push_r;
    logic [drvrs-1:0]     mask;
    logic [pckg_sz-1:0]   pkt;
    logic [pckg_sz-1:0]   head;
    logic [7:0]           head_id;

    // Head word of the granted source; stable through the POP cycle.
    assign head    = bus.D_pop[b][src];
    assign head_id = head[pckg_sz-1 -: 8];

    // Round-robin search: first pending source at or after rr_ptr, wrapping.
    always_comb begin : p_sel
      int idx;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < drvrs; i++) begin
        idx = (int'(rr_ptr) + i) % drvrs;
        if (!found && bus.pndng[b][idx]) begin
          found = 1'b1;
          sel   = sw'(idx);
        end
      end
    end

    // Destination mask from the head packet ID; out-of-range IDs give zero.
    always_comb begin
      mask = '0;
`ifdef BROADCAST_EN
      if (head_id == broadcast) begin
        mask      = '1;
        mask[src] = 1'b0;
      end else
`endif
      if (int'(head_id) < drvrs) begin
        mask[head_id[sw-1:0]] = 1'b1;
      end
    end

    // Per-bus transaction FSM with registered pop/push strobes and packet.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        rr_ptr <= '0;
        src    <= '0;
        pkt    <= '0;
        pop_r  <= '0;
        push_r <= '0;
      end else begin
        case (state)
          IDLE: begin
            push_r <= '0;
            if (found) begin
              src        <= sel;
              pop_r      <= '0;
              pop_r[sel] <= 1'b1;
              state      <= POP;
            end else begin
              pop_r <= '0;
            end
          end
          POP: begin
            pop_r  <= '0;
            pkt    <= head;
            push_r <= mask;
            state  <= PUSH;
          end
          PUSH: begin
            push_r <= '0;
            rr_ptr <= (src == sw'(drvrs - 1)) ? '0 : src + 1'b1;
            state  <= IDLE;
          end
          default: begin
            pop_r  <= '0;
            push_r <= '0;
            state  <= IDLE;
          end
        endcase
      end
    end

    assign bus.pop[b]    = pop_r;
    assign bus.push[b]   = push_r;
    assign bus.D_push[b] = pkt;
    assign dbg_state[b]  = state;
  end

endmodule

// File: tb/tb_bus_generator_and_arbiter.sv
// Directed bench for bus_generator_and_arbiter (bits=1, drvrs=4, pckg_sz=16).
module tb_bus_generator_and_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state [1];
  logic [0:0][1:0] dbg_state_w;
  int          checks;
  int          failures;

  dut_compl_if #(.bits(1), .drvrs(4), .pckg_sz(16)) bus_if ();

  bus_generator_and_arbiter #(
    .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.master),
    .dbg_state (dbg_state_w)
  );

  assign dbg_state[0] = dbg_state_w[0];

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr_inputs();
    bus_if.pndng = '0;
    bus_if.D_pop = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.pop !== 4'b0 || bus_if.push !== 4'b0 || bus_if.D_push !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs pop=%b push=%b d_push=%h required 0/0/0", bus_if.pop, bus_if.push, bus_if.D_push);
    end
    checks++;
    if (dbg_state[0] !== 2'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d required=0", dbg_state[0]);
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus_if.pop !== 4'b0 || bus_if.push !== 4'b0 || bus_if.D_push !== 16'h0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d pop=%b push=%b d_push=%h required 0/0/0", i, bus_if.pop, bus_if.push, bus_if.D_push);
      end
    end
  endtask

  // One transaction from a lone pending source; checks pop, push, data, idle.
  task automatic run_single(input string name, input int s, input logic [15:0] data,
                            input logic [3:0] exp_pop, input logic [3:0] exp_push);
    bus_if.pndng[0][s] = 1'b1;
    bus_if.D_pop[0][s] = data;
    @(negedge clk);
    checks++;
    if (bus_if.pop[0] !== exp_pop || bus_if.push[0] !== 4'b0) begin
      failures++;
      $display("FAIL %s_pop pop=%b push=%b required pop=%b push=0000", name, bus_if.pop[0], bus_if.push[0], exp_pop);
    end
    bus_if.pndng[0][s] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.push[0] !== exp_push || bus_if.pop[0] !== 4'b0) begin
      failures++;
      $display("FAIL %s_push push=%b pop=%b required push=%b pop=0000", name, bus_if.push[0], bus_if.pop[0], exp_push);
    end
    checks++;
    if (bus_if.D_push[0] !== data) begin
      failures++;
      $display("FAIL %s_data d_push=%h required=%h", name, bus_if.D_push[0], data);
    end
    @(negedge clk);
    checks++;
    if (bus_if.push[0] !== 4'b0 || bus_if.pop[0] !== 4'b0 || dbg_state[0] !== 2'd0 || bus_if.D_push[0] !== data) begin
      failures++;
      $display("FAIL %s_idle push=%b pop=%b state=%0d d_push=%h required 0000/0000/0/%h", name, bus_if.push[0], bus_if.pop[0], dbg_state[0], bus_if.D_push[0], data);
    end
    bus_if.D_pop[0][s] = '0;
  endtask

  task automatic test_unicast();
    // rr_ptr = 0 after reset; source 1 is the only requester.
    run_single("unicast", 1, 16'h0255, 4'b0010, 4'b0100);
  endtask

  task automatic test_invalid_id();
    run_single("invalid_id", 2, 16'h0700, 4'b0100, 4'b0000);
  endtask

  task automatic test_broadcast();
    logic [3:0] exp_push;
`ifdef BROADCAST_EN
    exp_push = 4'b0111;
`else
    exp_push = 4'b0000;
`endif
    run_single("broadcast", 3, 16'hFF12, 4'b1000, exp_push);
  endtask

  task automatic test_self_addressed();
    run_single("self_addr", 0, 16'h00AB, 4'b0001, 4'b0001);
  endtask

  // rr_ptr is 1 here; abort a POP with reset and confirm the grant restarts at 0.
  task automatic test_reset_mid();
    bus_if.pndng[0] = 4'b1111;
    bus_if.D_pop[0][0] = 16'h0311;
    bus_if.D_pop[0][1] = 16'h0022;
    @(negedge clk);
    checks++;
    if (bus_if.pop[0] !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_pop_before pop=%b required=0010", bus_if.pop[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.pop !== 4'b0 || bus_if.push !== 4'b0 || bus_if.D_push !== 16'h0 || dbg_state[0] !== 2'd0) begin
      failures++;
      $display("FAIL midrst_async pop=%b push=%b d_push=%h state=%0d required 0/0/0/0", bus_if.pop, bus_if.push, bus_if.D_push, dbg_state[0]);
    end
    @(negedge clk);
    checks++;
    if (bus_if.push !== 4'b0 || bus_if.pop !== 4'b0) begin
      failures++;
      $display("FAIL midrst_held push=%b pop=%b required 0000/0000", bus_if.push, bus_if.pop);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.pop[0] !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_restart pop=%b required=0001", bus_if.pop[0]);
    end
    bus_if.pndng[0] = 4'b0000;
    @(negedge clk);
    checks++;
    if (bus_if.push[0] !== 4'b1000 || bus_if.D_push[0] !== 16'h0311) begin
      failures++;
      $display("FAIL midrst_push push=%b d_push=%h required 1000/0311", bus_if.push[0], bus_if.D_push[0]);
    end
    @(negedge clk);
    clr_inputs();
  endtask

  // All sources pending from reset: pops 0,1,2,3,0,1 one every 3 cycles.
  task automatic test_back_to_back();
    logic [7:0]  id;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_push;
    logic [15:0] exp_data;
    int          s;
    int          phase;
    reset = 1'b0;
    for (int d = 0; d < 4; d++) begin
      id = 8'((d + 1) % 4);
      bus_if.D_pop[0][d] = {id, 8'(8'h50 + d)};
    end
    bus_if.pndng[0] = 4'b1111;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      s        = ((k - 1) / 3) % 4;
      phase    = (k - 1) % 3;
      exp_pop  = (phase == 0) ? 4'(1 << s) : 4'b0000;
      exp_push = (phase == 1) ? 4'(1 << ((s + 1) % 4)) : 4'b0000;
      exp_data = {8'((s + 1) % 4), 8'(8'h50 + s)};
      checks++;
      if (bus_if.pop[0] !== exp_pop || bus_if.push[0] !== exp_push) begin
        failures++;
        $display("FAIL rr_cycle k=%0d pop=%b push=%b required pop=%b push=%b", k, bus_if.pop[0], bus_if.push[0], exp_pop, exp_push);
      end
      if (phase == 1) begin
        checks++;
        if (bus_if.D_push[0] !== exp_data) begin
          failures++;
          $display("FAIL rr_data k=%0d d_push=%h required=%h", k, bus_if.D_push[0], exp_data);
        end
      end
    end
    clr_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clr_inputs();
    test_reset();
    test_unicast();
    test_invalid_id();
    test_broadcast();
    test_self_addressed();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
